// File: rtl/sha3_pkg.sv
// -----------------------------------------------------------------------------
// sha3_pkg
// Shared SHA-3 definitions used by the input padder, the rate selection and the
// digest transmitter.
//   sha3_mode_t        : digest length selector (224/256/384/512)
//   LANE_W             : Keccak lane / stream word width in bits
//   MAX_DIGEST_W       : widest digest in bits (eight lanes)
//   digest_last_idx    : index of the final lane of a digest of the given mode
//   digest_last_bytes  : valid bytes in that final lane (0 means all 8)
//   lane_select        : extracts one big-endian lane of a digest and blanks
//                        the bytes past the digest length on the final lane
// -----------------------------------------------------------------------------
package sha3_pkg;

  localparam int LANE_W       = 64;
  localparam int MAX_DIGEST_W = 512;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_mode_t;

  function automatic logic [2:0] digest_last_idx(input sha3_mode_t mode);
    logic [2:0] idx_s;
    case (mode)
      SHA3_224: idx_s = 3'd3;
      SHA3_256: idx_s = 3'd3;
      SHA3_384: idx_s = 3'd5;
      SHA3_512: idx_s = 3'd7;
      default:  idx_s = 3'd7;
    endcase
    return idx_s;
  endfunction

  // Only SHA3-224 (28 bytes) ends part-way through a lane.
  function automatic logic [2:0] digest_last_bytes(input sha3_mode_t mode);
    logic [2:0] bytes_s;
    case (mode)
      SHA3_224: bytes_s = 3'd4;
      SHA3_256: bytes_s = 3'd0;
      SHA3_384: bytes_s = 3'd0;
      SHA3_512: bytes_s = 3'd0;
      default:  bytes_s = 3'd0;
    endcase
    return bytes_s;
  endfunction

  // Lane 0 sits in the top 64 bits, so lane idx starts at bit 64*(7-idx).
  function automatic logic [LANE_W-1:0] lane_select(
    input logic [MAX_DIGEST_W-1:0] digest,
    input logic [2:0]              idx,
    input logic                    is_last,
    input logic [2:0]              last_bytes
  );
    logic [8:0]        base_s;
    logic [LANE_W-1:0] word_s;
    logic              keep_s;
    base_s = {3'd7 - idx, 6'd0};
    word_s = digest[base_s +: LANE_W];
    for (int b = 0; b < 8; b++) begin
      keep_s = !(is_last && (last_bytes != 3'd0) && (b >= int'(last_bytes)));
      word_s[LANE_W-1-8*b -: 8] = keep_s ? word_s[LANE_W-1-8*b -: 8] : 8'd0;
    end
    return word_s;
  endfunction

endpackage

// File: rtl/sha3_digest_tx.sv
// -----------------------------------------------------------------------------
// sha3_digest_tx
// Takes one finished Keccak digest from the permutation core and streams it out
// as 64-bit AXI-Stream words, first digest byte in TDATA[63:56].
//   ACLK, ARESET   : clock, asynchronous active-high reset
//   digest_valid   : digest_data / mode are valid
//   digest_ready   : a digest can be accepted this cycle
//   digest_data    : digest, byte 0 in [511:504]
//   mode           : 0=SHA3-224 1=SHA3-256 2=SHA3-384 3=SHA3-512
//   TDATA/TVALID/TREADY/TLAST : AXI-Stream master
//   byte_num       : valid bytes of the TLAST word (0 = all 8), 0 otherwise
// -----------------------------------------------------------------------------
module sha3_digest_tx #(
  parameter int DATA_W       = 64,
  parameter int MAX_DIGEST_W = 512
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    digest_valid,
  output logic                    digest_ready,
  input  logic [MAX_DIGEST_W-1:0] digest_data,
  input  logic [1:0]              mode,
  output logic [DATA_W-1:0]       TDATA,
  output logic                    TVALID,
  input  logic                    TREADY,
  output logic                    TLAST,
  output logic [2:0]              byte_num
);

  import sha3_pkg::sha3_mode_t;
  import sha3_pkg::digest_last_idx;
  import sha3_pkg::digest_last_bytes;
  import sha3_pkg::lane_select;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  tx_state_t                state_r;
  logic [2:0]               idx_r;
  logic [2:0]               last_idx_r;
  logic [2:0]               last_bytes_r;
  logic [MAX_DIGEST_W-1:0]  digest_r;
  logic [DATA_W-1:0]        tdata_r;
  logic                     tvalid_r;
  logic                     tlast_r;
  logic [2:0]               byte_num_r;

  logic                     beat_s;
  logic                     last_beat_s;
  logic                     ready_s;
  logic                     accept_s;
  sha3_mode_t               mode_s;
  logic [2:0]               new_last_idx_s;
  logic [2:0]               new_last_bytes_s;
  logic                     new_first_last_s;
  logic [DATA_W-1:0]        first_word_s;
  logic [2:0]               next_idx_s;
  logic                     next_last_s;
  logic [DATA_W-1:0]        next_word_s;

  // Handshake decode plus the word that will be presented after this edge.
  always_comb begin
    beat_s           = tvalid_r & TREADY;
    last_beat_s      = beat_s & tlast_r;
    // Ready on the final handshake lets a new digest follow with no gap.
    ready_s          = (state_r == ST_IDLE) | last_beat_s;
    accept_s         = digest_valid & ready_s;
    mode_s           = sha3_mode_t'(mode);
    new_last_idx_s   = digest_last_idx(mode_s);
    new_last_bytes_s = digest_last_bytes(mode_s);
    new_first_last_s = (new_last_idx_s == 3'd0);
    // The first word comes straight from the input so it is valid one cycle
    // after acceptance.
    first_word_s     = lane_select(digest_data, 3'd0, new_first_last_s, new_last_bytes_s);
    next_idx_s       = idx_r + 3'd1;
    next_last_s      = (next_idx_s == last_idx_r);
    next_word_s      = lane_select(digest_r, next_idx_s, next_last_s, last_bytes_r);
  end

  // Transmit FSM, lane counter and registered stream outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r      <= ST_IDLE;
      idx_r        <= 3'd0;
      last_idx_r   <= 3'd0;
      last_bytes_r <= 3'd0;
      digest_r     <= '0;
      tdata_r      <= '0;
      tvalid_r     <= 1'b0;
      tlast_r      <= 1'b0;
      byte_num_r   <= 3'd0;
    end else if (accept_s) begin
      state_r      <= ST_SEND;
      idx_r        <= 3'd0;
      last_idx_r   <= new_last_idx_s;
      last_bytes_r <= new_last_bytes_s;
      digest_r     <= digest_data;
      tdata_r      <= first_word_s;
      tvalid_r     <= 1'b1;
      tlast_r      <= new_first_last_s;
      byte_num_r   <= new_first_last_s ? new_last_bytes_s : 3'd0;
    end else if (last_beat_s) begin
      state_r      <= ST_IDLE;
      idx_r        <= 3'd0;
      tdata_r      <= '0;
      tvalid_r     <= 1'b0;
      tlast_r      <= 1'b0;
      byte_num_r   <= 3'd0;
    end else if (beat_s) begin
      idx_r        <= next_idx_s;
      tdata_r      <= next_word_s;
      tlast_r      <= next_last_s;
      byte_num_r   <= next_last_s ? last_bytes_r : 3'd0;
    end else begin
      // Stalled or idle: every output register holds its value.
      state_r      <= state_r;
    end
  end

  assign digest_ready = ready_s;
  assign TDATA        = tdata_r;
  assign TVALID       = tvalid_r;
  assign TLAST        = tlast_r;
  assign byte_num     = byte_num_r;

endmodule

// File: tb/tb_sha3_digest_tx.sv
module tb_sha3_digest_tx;

  logic         ACLK;
  logic         ARESET;
  logic         digest_valid;
  logic         digest_ready;
  logic [511:0] digest_data;
  logic [1:0]   mode;
  logic [63:0]  TDATA;
  logic         TVALID;
  logic         TREADY;
  logic         TLAST;
  logic [2:0]   byte_num;

  int n_cmp  = 0;
  int n_fail = 0;

  // Beats captured by collect_stream
  logic [63:0] obs_data [16];
  logic        obs_last [16];
  logic [2:0]  obs_bn   [16];
  int          obs_n;
  int          stable_err;
  int          gap_err;
  int          ready_err;
  int          late_first;
  int          stream_timeout;
  int          load_timeout;

  sha3_digest_tx dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .digest_data  (digest_data),
    .mode         (mode),
    .TDATA        (TDATA),
    .TVALID       (TVALID),
    .TREADY       (TREADY),
    .TLAST        (TLAST),
    .byte_num     (byte_num)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- reference model ----------------
  function automatic int exp_len(input logic [1:0] m);
    case (m)
      2'd0:    return 28;
      2'd1:    return 32;
      2'd2:    return 48;
      default: return 64;
    endcase
  endfunction

  function automatic int exp_words(input logic [1:0] m);
    return (exp_len(m) + 7) / 8;
  endfunction

  function automatic logic [63:0] exp_word(input logic [511:0] d, input logic [1:0] m, input int w);
    logic [63:0] r;
    int len;
    int k;
    len = exp_len(m);
    r = 64'd0;
    for (int b = 0; b < 8; b++) begin
      k = 8 * w + b;
      if (k < len) r[63-8*b -: 8] = d[511-8*k -: 8];
    end
    return r;
  endfunction

  function automatic logic [2:0] exp_bn(input logic [1:0] m, input int w);
    if (w == exp_words(m) - 1) return 3'(exp_len(m) % 8);
    return 3'd0;
  endfunction

  function automatic logic [511:0] rand_digest();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [511:0] counting_digest();
    logic [511:0] d;
    for (int k = 0; k < 64; k++) d[511-8*k -: 8] = 8'(k);
    return d;
  endfunction

  // ---------------- stimulus helpers (no comparisons) ----------------
  // Called at a negedge; returns at the negedge after acceptance.
  task automatic load_digest(input logic [511:0] d, input logic [1:0] m);
    int waited;
    load_timeout = 0;
    digest_valid = 1'b1;
    digest_data  = d;
    mode         = m;
    waited = 0;
    while (digest_ready !== 1'b1 && waited < 50) begin
      @(negedge ACLK);
      waited++;
    end
    if (waited >= 50) load_timeout = 1;
    @(negedge ACLK);
    digest_valid = 1'b0;
    digest_data  = rand_digest();
    mode         = 2'($urandom_range(0, 3));
  endtask

  // Called at the negedge where the first beat should be visible.
  task automatic collect_stream(input int stall_pct);
    logic        stalled;
    logic        done;
    logic [63:0] hd;
    logic        hl;
    logic [2:0]  hb;
    obs_n = 0; stable_err = 0; gap_err = 0; ready_err = 0;
    late_first = 0; stream_timeout = 0;
    stalled = 1'b0; done = 1'b0;
    hd = 64'd0; hl = 1'b0; hb = 3'd0;
    if (TVALID !== 1'b1) late_first = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (stalled && (TDATA !== hd || TLAST !== hl || byte_num !== hb)) stable_err++;
      if (TVALID === 1'b1) begin
        TREADY = ($urandom_range(0, 99) >= stall_pct);
        #1;
        if (digest_ready !== (TREADY & TLAST)) ready_err++;
        if (TREADY) begin
          if (obs_n < 16) begin
            obs_data[obs_n] = TDATA;
            obs_last[obs_n] = TLAST;
            obs_bn[obs_n]   = byte_num;
          end
          obs_n++;
          stalled = 1'b0;
          if (TLAST === 1'b1) done = 1'b1;
        end else begin
          stalled = 1'b1;
          hd = TDATA; hl = TLAST; hb = byte_num;
        end
      end else begin
        gap_err++;
        stalled = 1'b0;
        TREADY = 1'($urandom_range(0, 1));
      end
      // Input changes mid-stream must not reach the output.
      digest_data = rand_digest();
      mode        = 2'($urandom_range(0, 3));
      @(negedge ACLK);
      if (done) break;
    end
    TREADY = 1'b0;
    if (!done) stream_timeout = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    n_cmp++;
    if (TVALID !== 1'b0 || TLAST !== 1'b0 || TDATA !== 64'd0 || byte_num !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b last=%b data=%h bn=%0d, want 0/0/0/0", TVALID, TLAST, TDATA, byte_num);
    end
    ARESET = 1'b0;
    @(negedge ACLK);
    n_cmp++;
    if (digest_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", digest_ready);
    end
  endtask

  task automatic test_sha256_fixed();
    logic [511:0] d;
    logic [63:0]  want [4];
    want[0] = 64'h0001020304050607;
    want[1] = 64'h08090A0B0C0D0E0F;
    want[2] = 64'h1011121314151617;
    want[3] = 64'h18191A1B1C1D1E1F;
    d = counting_digest();
    load_digest(d, 2'd1);
    collect_stream(0);
    n_cmp++;
    if (obs_n !== 4 || stream_timeout != 0 || load_timeout != 0 || late_first != 0 || gap_err != 0) begin
      n_fail++;
      $display("FAIL sha256_shape: beats=%0d tmo=%0d/%0d late=%0d gaps=%0d, want 4 beats no errors", obs_n, stream_timeout, load_timeout, late_first, gap_err);
    end
    for (int w = 0; w < 4 && w < obs_n; w++) begin
      n_cmp++;
      if (obs_data[w] !== want[w] || obs_last[w] !== (w == 3) || obs_bn[w] !== 3'd0) begin
        n_fail++;
        $display("FAIL sha256_beat%0d: got %h last=%b bn=%0d, want %h last=%b bn=0", w, obs_data[w], obs_last[w], obs_bn[w], want[w], (w == 3));
      end
    end
    n_cmp++;
    if (TVALID !== 1'b0 || digest_ready !== 1'b1 || ready_err != 0) begin
      n_fail++;
      $display("FAIL sha256_idle: got valid=%b ready=%b ready_err=%0d, want 0/1/0", TVALID, digest_ready, ready_err);
    end
  endtask

  task automatic test_sha224_fixed();
    logic [511:0] d;
    d = rand_digest();
    d[511:288] = counting_digest() >> 288;
    d[287:256] = 32'hDEADBEEF;  // bytes 28..31 must be blanked
    load_digest(d, 2'd0);
    collect_stream(0);
    n_cmp++;
    if (obs_n !== 4 || stream_timeout != 0) begin
      n_fail++;
      $display("FAIL sha224_count: got %0d beats tmo=%0d, want 4", obs_n, stream_timeout);
    end
    for (int w = 0; w < 4 && w < obs_n; w++) begin
      n_cmp++;
      if (obs_data[w] !== exp_word(d, 2'd0, w) || obs_last[w] !== (w == 3) || obs_bn[w] !== exp_bn(2'd0, w)) begin
        n_fail++;
        $display("FAIL sha224_beat%0d: got %h last=%b bn=%0d, want %h last=%b bn=%0d", w, obs_data[w], obs_last[w], obs_bn[w], exp_word(d, 2'd0, w), (w == 3), exp_bn(2'd0, w));
      end
    end
    n_cmp++;
    if (obs_n >= 4 && (obs_data[3] !== 64'h18191A1B00000000 || obs_bn[3] !== 3'd4)) begin
      n_fail++;
      $display("FAIL sha224_last: got %h bn=%0d, want 18191a1b00000000 bn=4", obs_data[3], obs_bn[3]);
    end
  endtask

  task automatic test_sha512_stall();
    logic [511:0] d;
    d = counting_digest();
    load_digest(d, 2'd3);
    collect_stream(50);
    n_cmp++;
    if (obs_n !== 8 || stream_timeout != 0 || stable_err != 0 || gap_err != 0 || ready_err != 0) begin
      n_fail++;
      $display("FAIL sha512_stall: beats=%0d tmo=%0d unstable=%0d drops=%0d ready_err=%0d, want 8/0/0/0/0", obs_n, stream_timeout, stable_err, gap_err, ready_err);
    end
    for (int w = 0; w < 8 && w < obs_n; w++) begin
      n_cmp++;
      if (obs_data[w] !== exp_word(d, 2'd3, w) || obs_last[w] !== (w == 7) || obs_bn[w] !== 3'd0) begin
        n_fail++;
        $display("FAIL sha512_beat%0d: got %h last=%b bn=%0d, want %h last=%b bn=0", w, obs_data[w], obs_last[w], obs_bn[w], exp_word(d, 2'd3, w), (w == 7));
      end
    end
    n_cmp++;
    if (obs_n >= 8 && obs_data[7] !== 64'h38393A3B3C3D3E3F) begin
      n_fail++;
      $display("FAIL sha512_final: got %h want 38393a3b3c3d3e3f", obs_data[7]);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] d1;
    logic [511:0] d2;
    logic [1:0]   m2;
    d1 = rand_digest();
    d2 = rand_digest();
    m2 = 2'($urandom_range(0, 3));
    load_digest(d1, 2'd2);
    digest_valid = 1'b1;
    digest_data  = d2;
    mode         = m2;
    TREADY       = 1'b1;
    for (int b = 0; b < 6; b++) begin
      #1;
      n_cmp++;
      if (TVALID !== 1'b1 || TDATA !== exp_word(d1, 2'd2, b) || TLAST !== (b == 5) || digest_ready !== (b == 5)) begin
        n_fail++;
        $display("FAIL b2b_first_beat%0d: got valid=%b data=%h last=%b ready=%b, want 1/%h/%b/%b", b, TVALID, TDATA, TLAST, digest_ready, exp_word(d1, 2'd2, b), (b == 5), (b == 5));
      end
      @(negedge ACLK);
    end
    digest_valid = 1'b0;
    collect_stream(20);
    n_cmp++;
    if (late_first != 0 || obs_n !== exp_words(m2) || stream_timeout != 0) begin
      n_fail++;
      $display("FAIL b2b_second: late=%0d beats=%0d tmo=%0d, want 0/%0d/0", late_first, obs_n, stream_timeout, exp_words(m2));
    end
    for (int w = 0; w < obs_n && w < 8; w++) begin
      n_cmp++;
      if (obs_data[w] !== exp_word(d2, m2, w) || obs_bn[w] !== exp_bn(m2, w)) begin
        n_fail++;
        $display("FAIL b2b_second_beat%0d: got %h bn=%0d, want %h bn=%0d", w, obs_data[w], obs_bn[w], exp_word(d2, m2, w), exp_bn(m2, w));
      end
    end
  endtask

  task automatic test_areset_mid();
    logic [511:0] d;
    d = rand_digest();
    load_digest(d, 2'd3);
    TREADY = 1'b1;
    repeat (2) @(negedge ACLK);
    TREADY = 1'b0;
    #2 ARESET = 1'b1;
    #1;
    n_cmp++;
    if (TVALID !== 1'b0 || TLAST !== 1'b0 || TDATA !== 64'd0 || byte_num !== 3'd0) begin
      n_fail++;
      $display("FAIL areset_async: got valid=%b last=%b data=%h bn=%0d, want all 0", TVALID, TLAST, TDATA, byte_num);
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    n_cmp++;
    if (digest_ready !== 1'b1 || TVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_release: got ready=%b valid=%b, want 1/0", digest_ready, TVALID);
    end
    d = rand_digest();
    load_digest(d, 2'd1);
    collect_stream(25);
    n_cmp++;
    if (obs_n !== 4 || stream_timeout != 0 || stable_err != 0) begin
      n_fail++;
      $display("FAIL areset_restream: beats=%0d tmo=%0d unstable=%0d, want 4/0/0", obs_n, stream_timeout, stable_err);
    end
    for (int w = 0; w < 4 && w < obs_n; w++) begin
      n_cmp++;
      if (obs_data[w] !== exp_word(d, 2'd1, w) || obs_last[w] !== (w == 3)) begin
        n_fail++;
        $display("FAIL areset_beat%0d: got %h last=%b, want %h last=%b", w, obs_data[w], obs_last[w], exp_word(d, 2'd1, w), (w == 3));
      end
    end
  endtask

  task automatic test_random_modes();
    logic [511:0] d;
    logic [1:0]   m;
    for (int t = 0; t < 8; t++) begin
      d = rand_digest();
      m = 2'($urandom_range(0, 3));
      load_digest(d, m);
      collect_stream(int'($urandom_range(0, 60)));
      n_cmp++;
      if (obs_n !== exp_words(m) || stream_timeout != 0 || load_timeout != 0 || stable_err != 0 || gap_err != 0 || ready_err != 0 || late_first != 0) begin
        n_fail++;
        $display("FAIL random%0d_shape: mode=%0d beats=%0d tmo=%0d/%0d unstable=%0d gaps=%0d ready_err=%0d late=%0d, want %0d beats no errors", t, m, obs_n, stream_timeout, load_timeout, stable_err, gap_err, ready_err, late_first, exp_words(m));
      end
      for (int w = 0; w < obs_n && w < 8; w++) begin
        n_cmp++;
        if (obs_data[w] !== exp_word(d, m, w) || obs_last[w] !== (w == exp_words(m) - 1) || obs_bn[w] !== exp_bn(m, w)) begin
          n_fail++;
          $display("FAIL random%0d_beat%0d: got %h last=%b bn=%0d, want %h last=%b bn=%0d", t, w, obs_data[w], obs_last[w], obs_bn[w], exp_word(d, m, w), (w == exp_words(m) - 1), exp_bn(m, w));
        end
      end
    end
  endtask

  initial begin
    ARESET       = 1'b1;
    digest_valid = 1'b0;
    digest_data  = 512'd0;
    mode         = 2'd0;
    TREADY       = 1'b0;
    test_reset();
    test_sha256_fixed();
    test_sha224_fixed();
    test_sha512_stall();
    test_back_to_back();
    test_areset_mid();
    test_random_modes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sha3_digest_tx.md
Name: sha3_digest_tx

Overview:
- Output-side counterpart of the input padder: the padder turns an AXI-Stream message into padded 64-bit lanes; this block turns a finished Keccak digest back into an AXI-Stream of 64-bit words.
- Accepts one digest (up to 512 bits) from the permutation core via a valid/ready handshake.
- Emits it as 4–8 beats on an AXI-Stream master port.
- Marks the final beat with TLAST and a byte_num count of valid bytes in that word.

Parameters:
- DATA_W, 64, stream word width; only 64 is supported.
- MAX_DIGEST_W, 512, digest input width in bits; equals 8 words.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- digest_valid  in  1  digest_data and mode are valid.
- digest_ready  out  1  block can accept a digest.
- digest_data  in  512  digest; byte 0 is in [511:504]; bytes beyond the digest length are ignored.
- mode  in  2  digest length: 0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512.
- TDATA  out  64  stream word; first byte in [63:56].
- TVALID  out  1  stream word valid.
- TREADY  in  1  downstream accepts the word.
- TLAST  out  1  final word of the digest.
- byte_num  out  3  valid bytes in the final word; 0 means all 8 valid; driven 0 on non-last beats.

Behaviour:
- Reset, asynchronous and active-high, clears:
  - digest_ready=1 once ARESET deasserts;
  - TVALID=0, TLAST=0, byte_num=0, TDATA=0;
  - FSM to IDLE, word index to 0, latched digest to 0.
- Load:
  - When digest_valid & digest_ready, latch digest_data (512 bits) and mode.
  - Set last_idx and last_bytes from mode:
    - 224: last_idx 3, last_bytes 4
    - 256: last_idx 3, last_bytes 0
    - 384: last_idx 5, last_bytes 0
    - 512: last_idx 7, last_bytes 0
  - FSM goes to SEND with idx=0.
  - The first beat has TVALID=1 on the cycle after acceptance (latency 1).
- SEND:
  - TDATA = latched[511-64*idx -: 64].
  - On a 224 last beat, TDATA[31:0] is forced to 0.
  - TLAST = (idx==last_idx). byte_num = last_bytes when TLAST, else 0.
  - TDATA, TLAST and byte_num are registered and held stable while TVALID & !TREADY (AXI rule); TVALID never drops without a handshake.
  - Beat handshake (TVALID & TREADY), not last: idx+1 and the next word is presented the following cycle. No bubble is required; full throughput is 1 word/cycle.
  - Last-beat handshake: return to IDLE, TVALID=0 next cycle, unless a new digest is accepted the same cycle.
- digest_ready:
  - digest_ready = (state==IDLE) | (TVALID & TREADY & TLAST).
  - Back-to-back operation: a digest accepted on the last-beat handshake cycle gives first beat TVALID=1 the next cycle, with no idle gap.
- Index arithmetic: 3-bit idx never exceeds last_idx, so no wrap occurs. mode values are all legal; no error path.
- mode and digest_data are sampled only at acceptance; later changes have no effect mid-stream.
- TREADY held low indefinitely: the block stalls with outputs frozen and digest_ready=0.
- ARESET mid-stream: outputs clear immediately (asynchronous); the partial digest is discarded; no TLAST is emitted.

Decomposition:
- Shared package sha3_pkg:
  - typedef sha3_mode_t (enum 2 bits: SHA3_224, SHA3_256, SHA3_384, SHA3_512);
  - constants LANE_W=64, MAX_DIGEST_W=512;
  - function digest_last_idx(mode) returning 3 bits;
  - function digest_last_bytes(mode) returning 3 bits.
- These are the same constants the padder side and rate selection use.
- No sub-module; the FSM, index counter and word mux sit in one module.

Test Plan:
- SHA3-256 load, digest bytes 0x00..0x1F, TREADY=1 -> 4 beats on consecutive cycles:
  - TDATA 0x0001020304050607, 0x08090A0B0C0D0E0F, 0x1011121314151617, 0x18191A1B1C1D1E1F;
  - TLAST on beat 4 only, byte_num=0.
- SHA3-224, bytes 0x00..0x1B -> 4 beats; last TDATA=0x18191A1B00000000, TLAST=1, byte_num=4.
- SHA3-512 with TREADY toggling 1,0,0,1,0,1… ->
  - 8 beats in order 0x0001..07 through 0x38..3F;
  - TDATA, TLAST and byte_num stable during stalls;
  - TVALID never drops early.
- SHA3-384 followed immediately by a second digest held valid ->
  - second digest_ready=1 exactly on the 6th-beat handshake cycle;
  - first beat of the second digest on the next cycle, with no gap.
- ARESET pulsed after beat 2 of a 512 stream ->
  - TVALID, TLAST and TDATA go 0 asynchronously;
  - after release, digest_ready=1 and a new 256 digest streams correctly from idx 0.
- mode and digest_data changed during SEND -> output words are unchanged from the latched values.
